// File: rtl/if_id_stage_pkg.sv
// co_pipe_pkg: constants shared by the 5-stage MIPS-like pipeline (NOP encoding, PC step, opcodes)
package co_pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          PC_INC    = 4;
  localparam logic [5:0]  OP_RTYPE  = 6'b111111;
  localparam logic [5:0]  OP_ADDI   = 6'b110111;
  localparam logic [5:0]  OP_LW     = 6'b100001;
  localparam logic [5:0]  OP_SW     = 6'b100011;
  localparam logic [5:0]  OP_BEQ    = 6'b111011;
  localparam logic [5:0]  OP_BNE    = 6'b100101;
  localparam logic [5:0]  OP_J      = 6'b100010;
  localparam logic [5:0]  OP_JAL    = 6'b100111;
endpackage

// File: rtl/if_id_stage_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
//   clk_i  in  clock
//   rst_i  in  asynchronous reset, active-low
//   inc_i  in  count one event this cycle
//   cnt_o  out current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_cnt <= '0;
    else if (inc_i && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign cnt_o = r_cnt;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch (PC + next-PC mux) and IF/ID pipeline register
//   clk_i/rst_i        clock, asynchronous active-low reset
//   imem_addr_o        PC, drives instruction memory
//   imem_data_i        fetched word (combinational memory read)
//   stall_i            load-use stall: hold PC and IF/ID
//   jump_i             jump decoded for the instruction in ID
//   branch_taken_i/branch_target_i  branch redirect from EX/MEM
//   instr_o/pc_plus4_o/valid_o      IF/ID register contents
//   stall_cnt_o/flush_cnt_o         saturating event counters
module if_id_stage
  import co_pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [31:0]      imem_data_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_target_i,
  output logic [31:0]      instr_o,
  output logic [PC_W-1:0]  pc_plus4_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [PC_W-1:0] r_pc, r_pc4;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic [PC_W-1:0] w_pc_inc, w_br_tgt, w_jump_tgt, w_next_pc;
  logic            w_jump_eff, w_flush, w_stall_inc;
  // a jump waits in ID while stalled and only counts for a real instruction
  always_comb begin
    w_pc_inc    = r_pc + PC_W'(PC_INC);
    w_br_tgt    = branch_target_i & ~PC_W'(3);
    w_jump_tgt  = {r_pc4[PC_W-1:28], r_instr[25:0], 2'b00};
    w_jump_eff  = jump_i & r_valid & ~stall_i;
    w_flush     = branch_taken_i | w_jump_eff;
    w_stall_inc = stall_i & ~w_flush;
    w_next_pc   = branch_taken_i ? w_br_tgt :
                  w_jump_eff     ? w_jump_tgt :
                  stall_i        ? r_pc : w_pc_inc;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_pc    <= RESET_PC;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_flush) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (!stall_i) begin
        r_instr <= imem_data_i;
        r_pc4   <= w_pc_inc;
        r_valid <= 1'b1;
      end
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_stall_inc), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_flush), .cnt_o(flush_cnt_o)
  );
  assign imem_addr_o = r_pc;
  assign instr_o     = r_instr;
  assign pc_plus4_o  = r_pc4;
  assign valid_o     = r_valid;
endmodule
